uart_tx_queue: RTL and testbench
================================

# uart_tx_queue

Byte queue and frame launcher feeding the UART transmitter (TxUnit). Host logic pushes bytes into a synchronous FIFO. A control FSM pops one byte at a time, presents it on TxUnit's `data_in`, and pulses `send`. It then waits for TxUnit's `active_flag`/`done_flag` sequence before launching the next byte. Sits between the system bus/host and TxUnit, all in the system clock domain.

## Interface
- `DEPTH`, 16, FIFO entries; power of two, ≥ 2.
- `CW`, `$clog2(DEPTH)+1`, localparam, width of `count`.

Ports:
- `clock`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  reset; synchronous, active-low.
- `wr_en`  in  1  push request; `wr_data` is written when `wr_en && !full`.
- `wr_data`  in  8  byte to queue.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `count`  out  CW  bytes currently queued (excludes the byte in flight).
- `tx_send`  out  1  to TxUnit `send`.
- `tx_data`  out  8  to TxUnit `data_in`; held stable for the whole frame.
- `tx_active`  in  1  from TxUnit `active_flag`.
- `tx_done`  in  1  from TxUnit `done_flag`.
- `busy`  out  1  high while the FSM is not in IDLE.
- `ovf_clr`  in  1  clears `overflow` (only with `UART_TXQ_OVF_EN`).
- `overflow`  out  1  sticky: a push was attempted while `full`.

## Operation
- FIFO: circular buffer of `DEPTH` bytes.
  - Write and read pointers are `CW-1` bits wide and wrap naturally.
  - `count` is incremented on a push and decremented on a pop.
  - `count` is unchanged when a push and a pop occur in the same cycle.
- Push while `full`: byte dropped; pointers and `count` unchanged. A pop in the same cycle does not make room for it, because `full` is evaluated on the current registered `count`.
- FSM states and transitions:
  - IDLE: if `!empty`, go to LOAD.
  - LOAD: pop one entry; `tx_data <= mem[rd_ptr]`; go to SEND.
  - SEND: `tx_send = 1`. Stay until `tx_active` is sampled 1, then go to WAIT_DONE. This allows for TxUnit sampling `send` on its slower baud clock.
  - WAIT_DONE: `tx_send = 0`. When `tx_done` is sampled 1 and `tx_active` is 0, go to GAP.
  - GAP: one cycle; go to IDLE. This guarantees `tx_send` is low for at least 2 cycles between frames.
- `tx_send` is a registered output, high exactly while the FSM is in SEND.
- `tx_data` changes only in LOAD.
- `busy = (state != IDLE)`.
- Reset (synchronous, `reset_n == 0` at an edge) applies to any state, mid-frame included:
  - pointers, `count`, `tx_data`, `tx_send` and `overflow` go to 0; FSM goes to IDLE; queued bytes are discarded.
  - Output values: `empty = 1`, `full = 0`, `busy = 0`.
  - Memory contents are not reset.
- `tx_done` held high while IDLE (TxUnit idle state) is ignored. It is only examined in WAIT_DONE, after `tx_active` has been seen high.

## Timing
- Push into empty queue at edge N: `count = 1` and `empty = 0` after N; LOAD at N+1; `tx_data` valid and SEND (`tx_send = 1`) after N+2.
- Pop in LOAD: `count` decrements at the same edge that enters SEND.
- `tx_send` deasserts on the edge after `tx_active` is first sampled high.
- Back-to-back frames: next LOAD occurs 2 cycles (GAP, IDLE) after `tx_done` qualifies.
- `full`, `empty`, `count`, `busy` and `overflow` are all registered or derived from registered state only. There is no combinational path from inputs to outputs.

## Configuration
- `UART_TXQ_OVF_EN` defined:
  - `overflow` sets on any push attempted while `full`.
  - It clears on `ovf_clr`.
  - If set and clear coincide, set wins.
- Not defined: `overflow` is tied to 0 and `ovf_clr` is ignored. Dropping on full is unchanged.

## Test plan
- Reset, then push 0xA5 once: `tx_send` rises 2 cycles after the push edge with `tx_data = 0xA5`. After the model raises `tx_active`, `tx_send` falls next cycle; `count` returns to 0.
- Push 0x11, 0x22, 0x33 back-to-back: three frames are launched in order. `tx_data` is stable from LOAD until `tx_done`. `tx_send` is low ≥ 2 cycles between frames.
- With TxUnit model stalled (`tx_active` = 0), push DEPTH+2 bytes:
  - `count = DEPTH` and `full = 1`, not counting the one byte in flight.
  - Extra bytes are dropped.
  - `overflow = 1` with `UART_TXQ_OVF_EN`; `overflow = 0` without it.
- With `full = 1`, push and pop in the same cycle: push dropped, `count = DEPTH-1`.
- Assert `reset_n = 0` during WAIT_DONE with 5 bytes queued: next cycle `tx_send = 0`, `busy = 0`, `count = 0`, `empty = 1`, `tx_data = 0x00`.
- Push 40 bytes with DEPTH = 16 while draining concurrently: pointers wrap, all 40 bytes are transmitted in order, and none are lost.

Source files
------------

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO in front of TxUnit plus a small launcher FSM that
// pops one byte, raises send until TxUnit reports active, then waits for the
// active/done handshake and a one-cycle gap before the next frame.
// Optional feature macro: UART_TXQ_OVF_EN (sticky overflow flag, cleared by ovf_clr).
module uart_tx_queue #(
    parameter int  DEPTH = 16,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic          tx_send,
    output logic [7:0]    tx_data,
    input  logic          tx_active,
    input  logic          tx_done,
    output logic          busy,
    input  logic          ovf_clr,
    output logic          overflow
);

    localparam int AW = CW - 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_DONE,
        GAP
    } state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [7:0]    tx_data_reg;
    logic          tx_send_reg;
    state_t        state_reg;
    state_t        state_next;
    logic          push;
    logic          pop;

    // Flags come straight from the registered count, so no input reaches an output
    // combinationally. A push while full is judged on the pre-edge count, which is
    // why a pop in the same cycle cannot rescue it.
    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign busy    = (state_reg != IDLE);
    assign tx_send = tx_send_reg;
    assign tx_data = tx_data_reg;

    assign push = reset_n && wr_en && !full;
    // LOAD is only entered from IDLE with a non-empty queue, so a pop never underflows.
    assign pop  = (state_reg == LOAD);

    // Storage array: written on accepted pushes only, never cleared by reset.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointers and occupancy; pointers are exactly log2(DEPTH) bits and wrap on their own.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // State register plus the registered TxUnit-facing outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            tx_send_reg <= 1'b0;
            tx_data_reg <= 8'h00;
        end else begin
            state_reg   <= state_next;
            tx_send_reg <= (state_next == SEND);
            if (state_reg == LOAD) begin
                tx_data_reg <= mem[rd_ptr_reg];
            end
        end
    end

    // Next-state logic. tx_done is only trusted after active has been seen, because
    // TxUnit holds done high while it sits idle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (!empty) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = SEND;
            end
            SEND: begin
                if (tx_active) begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tx_done && !tx_active) begin
                    state_next = GAP;
                end
            end
            GAP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef UART_TXQ_OVF_EN
    logic overflow_reg;

    // Sticky overflow: any push attempted while full sets it; a coincident clear loses.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            overflow_reg <= 1'b0;
        end else if (wr_en && full) begin
            overflow_reg <= 1'b1;
        end else if (ovf_clr) begin
            overflow_reg <= 1'b0;
        end
    end

    assign overflow = overflow_reg;
`else
    logic unused_ovf_clr;

    assign unused_ovf_clr = ovf_clr;
    assign overflow       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: randomized bench for uart_tx_queue. A behavioural TxUnit
// answers send requests with random latencies; a queue-based reference model
// predicts occupancy, flags and the byte presented for every frame.
module tb_uart_tx_queue;

    localparam int DEPTH      = 16;
    localparam int CW         = $clog2(DEPTH) + 1;
    localparam int TXU_NORMAL = 0;
    localparam int TXU_STALL  = 1;
    localparam int TXU_HOLD   = 2;
`ifdef UART_TXQ_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset_n;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          tx_send;
    logic [7:0]    tx_data;
    logic          tx_active;
    logic          tx_done;
    logic          busy;
    logic          ovf_clr;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    // reference model: queued bytes, byte on TxUnit, and frame progress
    logic [7:0] m_q[$];
    logic [7:0] m_txd;
    bit         m_busy;
    bit         m_launch_cd;
    bit         m_sending;
    bit         m_armed;
    bit         m_release;
    bit         m_ovf;
    int         m_launched;
    int         m_accepted;

    // TxUnit behavioural model
    int txu_mode;
    int txu_delay;
    int txu_left;
    bit txu_pending;

    // spacing of send pulses
    bit prev_send;
    bit seen_frame;
    int low_run;

    uart_tx_queue #(.DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .tx_send   (tx_send),
        .tx_data   (tx_data),
        .tx_active (tx_active),
        .tx_done   (tx_done),
        .busy      (busy),
        .ovf_clr   (ovf_clr),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs held across that edge.
    task automatic model_edge();
        bit push_ok;
        bit do_pop;
        if (!reset_n) begin
            m_q.delete();
            m_txd       = 8'h00;
            m_busy      = 1'b0;
            m_launch_cd = 1'b0;
            m_sending   = 1'b0;
            m_armed     = 1'b0;
            m_release   = 1'b0;
            m_ovf       = 1'b0;
            return;
        end
        push_ok = wr_en && (m_q.size() < DEPTH);
        if (OVF_EN) begin
            if (wr_en && m_q.size() == DEPTH) m_ovf = 1'b1;
            else if (ovf_clr)                 m_ovf = 1'b0;
        end
        do_pop = 1'b0;
        if (m_sending) begin
            if (tx_active) begin
                m_sending = 1'b0;
                m_armed   = 1'b1;
            end
        end else if (m_armed) begin
            if (tx_done && !tx_active) begin
                m_armed   = 1'b0;
                m_release = 1'b1;
            end
        end else if (m_release) begin
            m_release = 1'b0;
            m_busy    = 1'b0;
        end else if (m_launch_cd) begin
            m_launch_cd = 1'b0;
            do_pop      = 1'b1;
            m_sending   = 1'b1;
        end else if (!m_busy && m_q.size() > 0) begin
            m_busy      = 1'b1;
            m_launch_cd = 1'b1;
        end
        if (do_pop) begin
            m_txd = m_q.pop_front();
            m_launched++;
        end
        if (push_ok) begin
            m_q.push_back(wr_data);
            m_accepted++;
        end
    endtask

    task automatic compare_all();
        check_val("count",    32'(count),    32'(m_q.size()));
        check_val("empty",    32'(empty),    32'(m_q.size() == 0));
        check_val("full",     32'(full),     32'(m_q.size() == DEPTH));
        check_val("busy",     32'(busy),     32'(m_busy));
        check_val("tx_send",  32'(tx_send),  32'(m_sending));
        check_val("tx_data",  32'(tx_data),  32'(m_txd));
        check_val("overflow", 32'(overflow), 32'(m_ovf));
        if (tx_send === 1'b1 && !prev_send) begin
            if (seen_frame) check_val("send_gap", 32'(low_run >= 2), 32'd1);
            seen_frame = 1'b1;
            low_run    = 0;
        end else if (tx_send === 1'b0) begin
            low_run++;
        end
        prev_send = (tx_send === 1'b1);
    endtask

    // TxUnit answer for the next edge, based on the send level just seen.
    task automatic txu_drive();
        if (txu_mode == TXU_STALL) begin
            tx_active   = 1'b0;
            txu_pending = 1'b0;
            return;
        end
        if (tx_active) begin
            if (txu_mode == TXU_NORMAL) begin
                if (txu_left > 0) begin
                    txu_left--;
                end else begin
                    tx_active = 1'b0;
                    tx_done   = 1'b1;
                end
            end
        end else if (txu_pending) begin
            if (txu_delay > 0) begin
                txu_delay--;
            end else begin
                tx_active   = 1'b1;
                tx_done     = 1'b0;
                txu_left    = $urandom_range(1, 4);
                txu_pending = 1'b0;
            end
        end else if (tx_send === 1'b1) begin
            txu_pending = 1'b1;
            txu_delay   = $urandom_range(0, 3);
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        compare_all();
        txu_drive();
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((m_busy || m_q.size() > 0) && n < limit) begin
            step();
            n++;
        end
        check_val("drain_done", 32'(m_busy || m_q.size() > 0), 32'd0);
    endtask

    initial begin
        int n;
        int acc0;
        int lau0;
        reset_n     = 1'b0;
        wr_en       = 1'b0;
        wr_data     = 8'h00;
        ovf_clr     = 1'b0;
        tx_active   = 1'b0;
        tx_done     = 1'b1;
        txu_mode    = TXU_NORMAL;
        txu_pending = 1'b0;
        txu_delay   = 0;
        txu_left    = 0;
        m_launched  = 0;
        m_accepted  = 0;
        prev_send   = 1'b0;
        seen_frame  = 1'b0;
        low_run     = 0;

        // reset state
        repeat (3) step();
        check_val("rst_empty", 32'(empty), 32'd1);
        check_val("rst_busy",  32'(busy),  32'd0);
        reset_n = 1'b1;
        step();

        // single byte: send two edges after the push
        wr_en   = 1'b1;
        wr_data = 8'hA5;
        step();
        wr_en = 1'b0;
        check_val("a5_count1", 32'(count), 32'd1);
        step();
        check_val("a5_send_early", 32'(tx_send), 32'd0);
        step();
        check_val("a5_send", 32'(tx_send), 32'd1);
        check_val("a5_data", 32'(tx_data), 32'hA5);
        check_val("a5_count0", 32'(count), 32'd0);
        drain(200);

        // three back-to-back bytes
        for (int i = 0; i < 3; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(8'h11 * (i + 1));
            step();
        end
        wr_en = 1'b0;
        drain(300);

        // stalled TxUnit: fill to DEPTH with one in flight, then overflow
        txu_mode = TXU_STALL;
        for (int i = 0; i < DEPTH + 2; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'($urandom);
            step();
        end
        wr_en = 1'b0;
        check_val("stall_count", 32'(count), 32'(DEPTH));
        check_val("stall_full",  32'(full),  32'd1);
        check_val("stall_ovf",   32'(overflow), 32'(OVF_EN));
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check_val("ovf_cleared", 32'(overflow), 32'd0);

        // release; push and clear coincide with the pop while full
        txu_mode = TXU_NORMAL;
        n = 0;
        while (!m_launch_cd && n < 100) begin
            step();
            n++;
        end
        check_val("load_reached", 32'(m_launch_cd), 32'd1);
        wr_en   = 1'b1;
        ovf_clr = 1'b1;
        wr_data = 8'($urandom);
        step();
        wr_en   = 1'b0;
        ovf_clr = 1'b0;
        check_val("fullpop_count", 32'(count), 32'(DEPTH - 1));
        check_val("fullpop_full",  32'(full),  32'd0);
        check_val("fullpop_ovf",   32'(overflow), 32'(OVF_EN));
        drain(2000);

        // reset in WAIT_DONE with five bytes queued
        txu_mode = TXU_HOLD;
        for (int i = 0; i < 6; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'($urandom);
            step();
        end
        wr_en = 1'b0;
        n = 0;
        while (!m_armed && n < 50) begin
            step();
            n++;
        end
        check_val("hold_armed", 32'(m_armed), 32'd1);
        check_val("hold_count", 32'(count), 32'd5);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check_val("midrst_send",  32'(tx_send), 32'd0);
        check_val("midrst_busy",  32'(busy),    32'd0);
        check_val("midrst_count", 32'(count),   32'd0);
        check_val("midrst_empty", 32'(empty),   32'd1);
        check_val("midrst_data",  32'(tx_data), 32'd0);
        txu_mode    = TXU_NORMAL;
        tx_active   = 1'b0;
        tx_done     = 1'b1;
        txu_pending = 1'b0;
        repeat (3) step();

        // 40 bytes through the queue while draining: pointers wrap
        acc0 = m_accepted;
        lau0 = m_launched;
        n = 0;
        while (m_accepted - acc0 < 40 && n < 3000) begin
            wr_en   = (m_q.size() < DEPTH) && ($urandom_range(0, 1) == 1);
            wr_data = 8'($urandom);
            step();
            n++;
        end
        wr_en = 1'b0;
        check_val("wrap_pushed", 32'(m_accepted - acc0), 32'd40);
        drain(3000);
        check_val("wrap_frames", 32'(m_launched - lau0), 32'd40);

        // free-running random traffic with overflow clears
        for (int i = 0; i < 300; i++) begin
            wr_en   = ($urandom_range(0, 9) < 7);
            ovf_clr = ($urandom_range(0, 9) == 0);
            wr_data = 8'($urandom);
            step();
        end
        wr_en   = 1'b0;
        ovf_clr = 1'b0;
        drain(3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=running exp=finished t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
